signed_bcd_converter: RTL
=========================

Name: signed_bcd_converter

Overview:
- Sequential converter from a (BITS+1)-bit two's-complement value to sign plus BCD digits for the 7-segment display path.
- Computes the absolute value, then runs a multi-cycle shift-add-3 (double-dabble) conversion.
- Valid/ready handshake on both sides; result is held until the consumer accepts it.
- Generalises the combinational two's-complement-to-sign/magnitude conversion:
  - width and digit count are parametrised;
  - the most-negative input is handled correctly;
  - BCD saturation is added.

Parameters:
- BITS, 8: magnitude width; input is BITS+1 bits (MSB = sign).
- DIGITS, 3: number of BCD output digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input value available.
- in_ready  out  1  converter can accept (IDLE only).
- twos_comp  in  BITS+1  two's-complement input.
- out_valid  out  1  result available, held until accepted.
- out_ready  in  1  consumer accepts result.
- out_sign  out  1  1 = negative.
- out_mag  out  BITS+1  binary magnitude, range 0..2^BITS.
- out_bcd  out  4*DIGITS  BCD digits, digit 0 in bits [3:0].
- out_overflow  out  1  magnitude exceeds 10^DIGITS-1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; out_valid, out_sign, out_mag, out_bcd and out_overflow all 0; iteration counter 0.
  - in_ready is 0 while rst_n is low.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready, capture twos_comp:
    - sign = twos_comp[BITS];
    - mag = sign ? (~twos_comp + 1) : twos_comp, computed in BITS+1 bits so -2^BITS gives 2^BITS with no wrap.
  - Load the shift register {BCD = 0, bin = mag}; counter = BITS+1; go to CONVERT.
- CONVERT:
  - in_ready = 0.
  - Each cycle: every BCD digit >= 5 gets +3, then the whole {BCD, bin} register shifts left by 1; counter decrements.
  - After the BITS+1-th shift, go to DONE and register the outputs.
  - Internal BCD register is DIGITS+1 digits wide so that overflow is detectable.
- DONE entry registers:
  - out_sign, out_mag;
  - out_overflow = 1 if the upper digit is non-zero or any digit is out of range;
  - out_bcd = all 9s when out_overflow = 1, otherwise the low DIGITS digits.
- Latency:
  - out_valid rises exactly BITS+1 cycles after the accepting edge.
  - Default BITS=8: 9 cycles.
- DONE:
  - out_valid = 1; in_ready = 0.
  - Outputs are stable while out_ready = 0.
  - On an edge with out_valid & out_ready: out_valid goes to 0 and the state returns to IDLE.
  - No overlap: the earliest next accept is the cycle after the output handshake.
- in_valid outside IDLE is ignored; twos_comp is sampled only on the accepting edge.
- Zero input gives out_sign = 0 (no negative zero).
- out_sign, out_mag, out_bcd and out_overflow keep their last values after the handshake until the next DONE entry.
- rst_n asserted mid-CONVERT or mid-DONE:
  - immediate return to the reset state;
  - the partial result is discarded and no out_valid pulse is produced.
- Elaboration check: DIGITS >= 1 and BITS >= 1; otherwise fatal.

Decomposition:
- Shared package (display_pkg):
  - state enum {IDLE, CONVERT, DONE};
  - BCD_W = 4;
  - ADD3_THRESHOLD = 5;
  - function clog2 for counter width.
- Sub-module bcd_digit_adjust (combinational, parameter N digits): applies the conditional +3 to every 4-bit digit of the BCD vector. It is instantiated once with N = DIGITS+1.

Test Plan:
- BITS=8, DIGITS=3, twos_comp=9'h07B (+123): out_valid rises 9 cycles after the accepting edge, with out_sign=0, out_mag=123, out_bcd=12'h123, out_overflow=0.
- twos_comp=9'h1FF (-1): out_sign=1, out_mag=1, out_bcd=12'h001. Also twos_comp=9'h000 gives out_sign=0, out_bcd=12'h000.
- twos_comp=9'h100 (-256): out_sign=1, out_mag=256, out_bcd=12'h256, no wrap to 0.
- Instance BITS=8, DIGITS=2, input +100 (9'h064): out_overflow=1, out_bcd=8'h99, out_mag=100. Input +99 gives out_overflow=0, out_bcd=8'h99.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with a new value:
  - outputs stay unchanged and in_ready=0;
  - out_ready=1 for one edge drops out_valid and makes in_ready=1;
  - the next value is accepted on the following edge.
- Reset mid-CONVERT: pull rst_n low 4 cycles after accepting +200:
  - all outputs return to 0 immediately (asynchronously);
  - after release, no out_valid appears without a new handshake;
  - a fresh -45 converts to sign=1, out_bcd=12'h045.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the signed binary to BCD display path: converter
// state encoding, BCD digit constants and a constant-evaluable log2 helper.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int BCD_W          = 4;
    localparam int ADD3_THRESHOLD = 5;

    // Ceiling log2, used to size the iteration counter at elaboration time.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'd1 << result) < 32'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction step: every 4-bit BCD digit that is 5 or more gets
// +3, so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust
    import display_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N*BCD_W-1:0] bcd_in,
    output logic [N*BCD_W-1:0] bcd_out
);

    localparam logic [BCD_W-1:0] THRESH = BCD_W'(ADD3_THRESHOLD);
    localparam logic [BCD_W-1:0] ADD3   = BCD_W'(3);

    // Conditionally add 3 to each digit ahead of the next shift
    always_comb begin
        bcd_out = '0;
        for (int i = 0; i < N; i++) begin
            if (bcd_in[i*BCD_W +: BCD_W] >= THRESH) begin
                bcd_out[i*BCD_W +: BCD_W] = bcd_in[i*BCD_W +: BCD_W] + ADD3;
            end else begin
                bcd_out[i*BCD_W +: BCD_W] = bcd_in[i*BCD_W +: BCD_W];
            end
        end
    end

endmodule

// File: rtl/signed_bcd_converter.sv
// Sequential two's-complement to sign + BCD converter for the 7-segment path.
// Captures the absolute value in BITS+1 bits (so -2^BITS is exact), runs
// BITS+1 shift-add-3 iterations over a DIGITS+1 digit scratch register and
// saturates the displayed digits to all 9s when the magnitude does not fit.
module signed_bcd_converter
    import display_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS:0]         twos_comp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [BITS:0]         out_mag,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_overflow
);

    localparam int MAG_W     = BITS + 1;
    localparam int INT_DIG   = DIGITS + 1;
    localparam int BCD_INT_W = INT_DIG * BCD_W;
    localparam int OUT_BCD_W = DIGITS * BCD_W;
    localparam int SR_W      = BCD_INT_W + MAG_W;
    localparam int CNT_W     = clog2(BITS + 2);

    if (DIGITS < 1 || BITS < 1) begin : g_bad_params
        $fatal(1, "signed_bcd_converter: BITS and DIGITS must both be >= 1");
    end

    state_t                 state_r;
    state_t                 state_s;
    logic [SR_W-1:0]        shift_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   lost_r;
    logic                   sign_r;
    logic [MAG_W-1:0]       mag_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   out_sign_r;
    logic [MAG_W-1:0]       out_mag_r;
    logic [OUT_BCD_W-1:0]   out_bcd_r;
    logic                   out_overflow_r;

    logic                   accept_s;
    logic                   release_s;
    logic                   last_s;
    logic                   sign_s;
    logic [MAG_W-1:0]       mag_s;
    logic [BCD_INT_W-1:0]   adj_bcd_s;
    logic [SR_W-1:0]        shifted_s;
    logic                   lost_s;
    logic [BCD_INT_W-1:0]   final_bcd_s;
    logic                   ovf_s;
    logic [OUT_BCD_W-1:0]   bcd_low_s;

    // True when any digit in a BCD vector holds a code above 9.
    function automatic logic bcd_has_invalid(input logic [BCD_INT_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < INT_DIG; i++) begin
            if (bcd[i*BCD_W +: BCD_W] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    bcd_digit_adjust #(
        .N (INT_DIG)
    ) u_adjust (
        .bcd_in  (shift_r[SR_W-1 -: BCD_INT_W]),
        .bcd_out (adj_bcd_s)
    );

    // Handshake qualifiers and the final-iteration marker
    always_comb begin
        accept_s  = in_valid & in_ready_r & (state_r == IDLE);
        release_s = out_valid_r & out_ready;
        last_s    = (state_r == CONVERT) && (cnt_r == CNT_W'(1));
    end

    // Input magnitude, one double-dabble step and the saturated result
    always_comb begin
        sign_s      = twos_comp[BITS];
        if (sign_s) begin
            mag_s = ~twos_comp + {{BITS{1'b0}}, 1'b1};
        end else begin
            mag_s = twos_comp;
        end
        shifted_s   = {adj_bcd_s[BCD_INT_W-2:0], shift_r[MAG_W-1:0], 1'b0};
        lost_s      = adj_bcd_s[BCD_INT_W-1];
        final_bcd_s = shifted_s[SR_W-1 -: BCD_INT_W];
        ovf_s       = lost_r | lost_s
                    | (final_bcd_s[BCD_INT_W-1 -: BCD_W] != 4'd0)
                    | bcd_has_invalid(final_bcd_s);
        if (ovf_s) begin
            bcd_low_s = {DIGITS{4'h9}};
        end else begin
            bcd_low_s = final_bcd_s[OUT_BCD_W-1:0];
        end
    end

    // Next-state logic for IDLE -> CONVERT -> DONE -> IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = CONVERT;
                else          state_s = IDLE;
            end
            CONVERT: begin
                if (last_s) state_s = DONE;
                else        state_s = CONVERT;
            end
            DONE: begin
                if (release_s) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered handshake flags; in_ready stays low throughout reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r <= (state_s == IDLE);
            if (last_s) begin
                out_valid_r <= 1'b1;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Capture, shift-add-3 iterations and result registers loaded on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r        <= '0;
            cnt_r          <= '0;
            lost_r         <= 1'b0;
            sign_r         <= 1'b0;
            mag_r          <= '0;
            out_sign_r     <= 1'b0;
            out_mag_r      <= '0;
            out_bcd_r      <= '0;
            out_overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shift_r <= {{BCD_INT_W{1'b0}}, mag_s};
                        cnt_r   <= CNT_W'(BITS + 1);
                        lost_r  <= 1'b0;
                        sign_r  <= sign_s;
                        mag_r   <= mag_s;
                    end
                end
                CONVERT: begin
                    shift_r <= shifted_s;
                    cnt_r   <= cnt_r - CNT_W'(1);
                    lost_r  <= lost_r | lost_s;
                    if (last_s) begin
                        out_sign_r     <= sign_r;
                        out_mag_r      <= mag_r;
                        out_bcd_r      <= bcd_low_s;
                        out_overflow_r <= ovf_s;
                    end
                end
                DONE: begin
                    cnt_r <= '0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_sign     = out_sign_r;
    assign out_mag      = out_mag_r;
    assign out_bcd      = out_bcd_r;
    assign out_overflow = out_overflow_r;

endmodule
